ring_osc_nand2_monitor: RTL and testbench
=========================================

// Module: ring_osc_nand2_monitor
// PURPOSE
//   Process/speed monitor for a ring oscillator built from nand2 cells.
//   - Upstream role: drives the ring enable OSC_EN, which ties to the A1 pin of the ring's nand2 stage.
//   - Downstream role: consumes the ring output (that nand2's ZN, after the ring's divider) on OSC_IN.
//   - Counts OSC_IN rising edges over a programmable window of CLK cycles and reports a
//     saturating count for the oscillator-frequency readout.
// PARAMETERS
//   CNT_W       16  width of edge counter / COUNT output
//   WIN_W       16  width of WINDOW input (measurement length in CLK cycles)
//   SETTLE_CYC  8   CLK cycles OSC_EN is high before counting starts (>=SYNC_STAGES+1)
//   SYNC_STAGES 2   flops in the OSC_IN synchronizer (>=2)
// PORTS
//   CLK     in   1      single clock; all state on rising edge
//   RST     in   1      synchronous, active-high reset
//   START   in   1      request a measurement; sampled only in IDLE
//   WINDOW  in   WIN_W  measurement length; captured on the accepted START
//   OSC_IN  in   1      asynchronous ring output, frequency < CLK/4
//   OSC_EN  out  1      ring enable (high in SETTLE and MEASURE)
//   BUSY    out  1      high in every state except IDLE
//   DONE    out  1      one-cycle pulse when COUNT is valid
//   COUNT   out  CNT_W  result; holds until the next accepted START
//   OVF     out  1      counter saturated during the last measurement
// BEHAVIOUR
//   - Reset (RST=1 at a CLK edge): state=IDLE, OSC_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0,
//     synchronizer and edge-detect flops=0. Reset mid-measurement aborts: OSC_EN drops on that
//     same edge, no DONE pulse.
//   - FSM IDLE -> SETTLE -> MEASURE -> FINISH -> IDLE.
//     - IDLE: START=1 captures WINDOW, clears COUNT and OVF, goes to SETTLE.
//       BUSY=1 and OSC_EN=1 from the next cycle.
//     - IDLE with WINDOW=0: go straight to FINISH. OSC_EN stays 0, COUNT=0.
//     - SETTLE: exactly SETTLE_CYC cycles. The synchronizer runs but no edges are counted.
//       The edge-detect history loads the current synced value, so a high level at entry to
//       MEASURE is never counted as an edge.
//     - MEASURE: exactly WINDOW cycles. A rising edge of synced OSC_IN (sync=1, prev=0)
//       increments COUNT.
//     - FINISH: OSC_EN=0, DONE=1 for this one cycle, then IDLE. BUSY drops with the return to IDLE.
//   - Latency: START at edge n -> DONE high in cycle n+1+SETTLE_CYC+WINDOW.
//   - Saturation: at COUNT=2^CNT_W-1 a further edge leaves COUNT unchanged and sets OVF.
//     OVF stays sticky until the next START.
//   - START while BUSY is ignored, and WINDOW changes while BUSY have no effect.
//   - START asserted during the FINISH cycle is ignored. It is accepted only in IDLE.
//   - COUNT is stable and valid from the DONE cycle until the next accepted START.
// CONFIGURATION
//   Macro RO_MON_BOTH_EDGES_EN:
//   - Defined: MEASURE counts both rising and falling edges of synced OSC_IN (half-period
//     resolution). Saturation and OVF are unchanged.
//   - Undefined: rising edges only.
//   - Port list is identical in both builds.
// TESTING
//   1. RST=1 for 2 cycles while OSC_IN toggles -> all outputs 0. OSC_IN activity in IDLE
//      never changes COUNT.
//   2. SETTLE_CYC=8, WINDOW=100, OSC_IN period 10 CLK:
//      - DONE at START+109.
//      - COUNT=10 (both-edges build: 20). OVF=0.
//      - OSC_EN high for exactly 108 cycles.
//   3. CNT_W=4, WINDOW=200, OSC_IN period 8 CLK -> COUNT=15, OVF=1, DONE pulses once.
//   4. WINDOW=0 with START=1 -> DONE one cycle later, COUNT=0, OSC_EN never asserted.
//   5. START pulsed during MEASURE with a new WINDOW=5 -> ignored. First result completes
//      with the original window.
//   6. RST=1 mid-MEASURE -> OSC_EN=0 and BUSY=0 next cycle, no DONE, COUNT=0.
//      A fresh START then measures correctly.

Source files
------------

// File: rtl/ring_osc_nand2_monitor.sv
// Ring-oscillator speed monitor: enables the nand2 ring, then counts synchronized osc_in edges over a window of clk cycles.
// Build option: define RO_MON_BOTH_EDGES_EN to count rising and falling edges (half-period resolution).
module ring_osc_nand2_monitor #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);
    // state    | meaning
    // IDLE     | waiting for start, last result held
    // SETTLE   | ring enabled, synchronizer filling, edges ignored
    // MEASURE  | counting edges for the captured window
    // FINISH   | ring off, one-cycle done pulse
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    logic [1:0]             state;
    logic [TMR_W-1:0]       tmr;
    logic [WIN_W-1:0]       win_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;
    logic                   osc_edge;
    logic                   tmr_tc;

    assign synced = sync_q[SYNC_STAGES-1];
    assign tmr_tc = (tmr == '0);

`ifdef RO_MON_BOTH_EDGES_EN
    assign osc_edge = synced ^ prev_q;
`else
    assign osc_edge = synced & ~prev_q;
`endif

    assign osc_en = (state == S_SETTLE) || (state == S_MEASURE);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tmr   <= '0;
            win_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        win_q <= window;
                        if (window == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state <= S_SETTLE;
                            tmr   <= SETTLE_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tmr_tc) begin
                        state <= S_MEASURE;
                        tmr   <= TMR_W'(win_q) - TMR_W'(1);
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (tmr_tc) begin
                        state <= S_FINISH;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // History follows the synced value in every state, so a level already high when MEASURE begins is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= synced;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if ((state == S_MEASURE) && osc_edge) begin
            if (&count) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_nand2_monitor.sv
// Bench for ring_osc_nand2_monitor: two instances (16-bit and 4-bit counters) share stimulus;
// expected counts come from the recorded osc_in history, counted over the measurement window.
`timescale 1ns/1ps
module tb_ring_osc_nand2_monitor;
    localparam int SETTLE = 8;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] window = 16'd0;
    logic        osc_in = 1'b0;

    logic        osc_en16, busy16, done16, ovf16;
    logic [15:0] count16;
    logic        osc_en4, busy4, done4, ovf4;
    logic [3:0]  count4;

    int   cyc = 0;
    int   per = 6, hi = 3, ph = 0;
    logic vhist [0:65535];
    int   chk = 0, passed = 0;

    ring_osc_nand2_monitor #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) u16 (
        .clk(clk), .rst(rst), .start(start), .window(window), .osc_in(osc_in),
        .osc_en(osc_en16), .busy(busy16), .done(done16), .count(count16), .ovf(ovf16));

    ring_osc_nand2_monitor #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) u4 (
        .clk(clk), .rst(rst), .start(start), .window(window), .osc_in(osc_in),
        .osc_en(osc_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4));

    always #5 clk = ~clk;

    // Free-running ring stand-in; vhist[t] is the level driven just after clock edge t.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        osc_in = (((cyc + ph) % per) < hi);
        vhist[cyc] = osc_in;
    end

    // Edges seen by the monitor: synced value lags the pin by SYNC cycles, window opens SETTLE cycles after start.
    function automatic int raw_edges(input int n, input int w);
        int r = 0;
        for (int j = n + SETTLE; j < n + SETTLE + w; j++) begin
`ifdef RO_MON_BOTH_EDGES_EN
            if (vhist[j-SYNC] != vhist[j-1-SYNC]) r++;
`else
            if (vhist[j-SYNC] == 1'b1 && vhist[j-1-SYNC] == 1'b0) r++;
`endif
        end
        return r;
    endfunction

    task automatic run_measure(input string tag, input int w, input int disturb_at, input bit poke_finish);
        int n, s_eff, exp_done, en_cnt, raw, done_at, e16, e4;
        bit o16, o4, seen, bad_busy;
        @(posedge clk); #2;
        start = 1'b1;
        window = 16'(w);
        @(posedge clk); #2;
        n = cyc;
        start = 1'b0;
        window = 16'($urandom);
        s_eff = (w == 0) ? 0 : SETTLE;
        exp_done = n + s_eff + w;
        en_cnt = 0; seen = 0; bad_busy = 0; done_at = -1;
        for (int k = 0; k < s_eff + w + 20 && !seen; k++) begin
            @(negedge clk);
            if (osc_en16) en_cnt++;
            if (done16) begin
                seen = 1;
                done_at = cyc;
            end else if (!busy16 || !busy4) begin
                bad_busy = 1;
            end
            if (disturb_at > 0 && k == disturb_at) begin
                start = 1'b1;
                window = 16'd5;
            end else if (disturb_at > 0 && k == disturb_at + 1) begin
                start = 1'b0;
            end
        end
        raw = raw_edges(n, w);
        e16 = (raw > 65535) ? 65535 : raw;
        o16 = (raw > 65535);
        e4  = (raw > 15) ? 15 : raw;
        o4  = (raw > 15);

        chk++;
        if (!seen) $display("FAIL %s done_timeout: no done within %0d cycles", tag, s_eff + w + 20);
        else passed++;
        chk++;
        if (done_at != exp_done) $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_at - n, exp_done - n);
        else passed++;
        chk++;
        if (count16 !== 16'(e16) || ovf16 !== o16)
            $display("FAIL %s count16: got %0d ovf %b expected %0d ovf %b", tag, count16, ovf16, e16, o16);
        else passed++;
        chk++;
        if (count4 !== 4'(e4) || ovf4 !== o4 || done4 !== 1'b1)
            $display("FAIL %s count4: got %0d ovf %b done %b expected %0d ovf %b done 1", tag, count4, ovf4, done4, e4, o4);
        else passed++;
        chk++;
        if (en_cnt != s_eff + w) $display("FAIL %s osc_en_cycles: got %0d expected %0d", tag, en_cnt, s_eff + w);
        else passed++;
        chk++;
        if (bad_busy) $display("FAIL %s busy_during_run: got 0 expected 1", tag);
        else passed++;

        if (poke_finish) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk++;
        if (done16 !== 1'b0 || busy16 !== 1'b0 || osc_en16 !== 1'b0)
            $display("FAIL %s after_done: done %b busy %b osc_en %b expected 0 0 0", tag, done16, busy16, osc_en16);
        else passed++;
        repeat (6) @(negedge clk);
        chk++;
        if (count16 !== 16'(e16) || busy16 !== 1'b0)
            $display("FAIL %s count_hold: got %0d busy %b expected %0d busy 0", tag, count16, busy16, e16);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk++;
        if ({osc_en16, busy16, done16, ovf16, count16} !== 20'd0 || {osc_en4, busy4, done4, ovf4, count4} !== 8'd0)
            $display("FAIL reset_outputs: u16 %b%b%b%b %0d u4 %b%b%b%b %0d expected all 0",
                     osc_en16, busy16, done16, ovf16, count16, osc_en4, busy4, done4, ovf4, count4);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_idle_activity;
        bit bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (count16 !== 16'd0 || busy16 !== 1'b0 || osc_en16 !== 1'b0 || done16 !== 1'b0) bad = 1;
        end
        chk++;
        if (bad) $display("FAIL idle_activity: count %0d busy %b osc_en %b expected 0 0 0", count16, busy16, osc_en16);
        else passed++;
    endtask

    task automatic test_nominal;
        per = 10; hi = 5; ph = $urandom_range(0, 9);
        run_measure("nominal", 100, 0, 0);
    endtask

    task automatic test_saturation;
        per = 8; hi = 4; ph = $urandom_range(0, 7);
        run_measure("saturate", 200, 0, 0);
    endtask

    task automatic test_zero_window;
        run_measure("zero_window", 0, 0, 0);
    endtask

    task automatic test_start_while_busy;
        per = 7; hi = 3;
        run_measure("start_busy", 40, SETTLE + 10, 0);
    endtask

    task automatic test_back_to_back;
        per = 9; hi = 4;
        run_measure("finish_start", 20, 0, 1);
        run_measure("back_to_back", 25, 0, 0);
    endtask

    task automatic test_reset_mid_measure;
        bit bad = 0;
        per = 5; hi = 2;
        @(posedge clk); #2;
        start = 1'b1;
        window = 16'd60;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (SETTLE + 20) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        chk++;
        if (osc_en16 !== 1'b0 || busy16 !== 1'b0 || done16 !== 1'b0 || count16 !== 16'd0 || count4 !== 4'd0 || ovf4 !== 1'b0)
            $display("FAIL reset_mid: osc_en %b busy %b done %b count %0d count4 %0d ovf4 %b expected all 0",
                     osc_en16, busy16, done16, count16, count4, ovf4);
        else passed++;
        rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done16 || done4 || busy16 || osc_en16) bad = 1;
        end
        chk++;
        if (bad) $display("FAIL reset_mid_no_done: got activity after abort expected none");
        else passed++;
        run_measure("after_reset", 30, 0, 0);
    endtask

    task automatic test_random;
        int w;
        for (int i = 0; i < 12; i++) begin
            per = $urandom_range(5, 14);
            hi  = $urandom_range(2, per - 2);
            ph  = $urandom_range(0, per - 1);
            w   = (i % 5 == 4) ? 0 : $urandom_range(1, 150);
            run_measure($sformatf("random%0d", i), w, 0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_idle_activity;
        test_nominal;
        test_saturation;
        test_zero_window;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_measure;
        test_random;
        $display("%0d/%0d checks passed", passed, chk);
        $finish;
    end

endmodule
